// File: rtl/ring_rr_arbiter_pkg.sv
// Shared types and combinational helpers for the ring round-robin arbiter.
// Helpers operate on a fixed maximum width; callers pass the live width n.
package ring_arb_pkg;

  localparam int unsigned MAXW = 32;
  localparam int unsigned MIW  = 5;

  typedef logic [MAXW-1:0] vec_t;
  typedef logic [MIW-1:0]  idx_t;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_e;

  // Rotate left by one within the low n bits; bit n-1 wraps to bit 0.
  function automatic vec_t rotl1(input vec_t v, input int unsigned n);
    vec_t r;
    r = '0;
    for (int unsigned i = 0; i < MAXW; i++) begin
      if (i < n) r[(i + 1 == n) ? idx_t'(0) : idx_t'(i + 1)] = v[idx_t'(i)];
    end
    return r;
  endfunction

  function automatic idx_t onehot2idx(input vec_t v);
    idx_t r;
    r = '0;
    for (int unsigned i = 0; i < MAXW; i++) begin
      if (v[idx_t'(i)]) r = r | idx_t'(i);
    end
    return r;
  endfunction

  // First set request at or above the token position, wrapping n-1 -> 0.
  function automatic vec_t rr_pick(input vec_t req, input vec_t token, input int unsigned n);
    vec_t        r;
    logic        found;
    int unsigned base;
    int unsigned j;
    r     = '0;
    found = 1'b0;
    base  = 32'(onehot2idx(token));
    for (int unsigned k = 0; k < MAXW; k++) begin
      if (k < n && !found) begin
        j = base + k;
        if (j >= n) j = j - n;
        if (req[idx_t'(j)]) begin
          r[idx_t'(j)] = 1'b1;
          found        = 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_rr_arbiter_if.sv
// Requester-side bundle of the ring arbiter: requests, releases and grant status.
interface ring_rr_arbiter_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
);
  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic [N-1:0]   token;
  logic           timeout;

  modport master (output req, done, input gnt, gnt_valid, gnt_id, token, timeout);
  modport slave  (input req, done, output gnt, gnt_valid, gnt_id, token, timeout);
endinterface

// File: rtl/ring_rr_arbiter_token.sv
// One-hot priority token register; on advance it loads the rotated grant vector.
module token_ring
  import ring_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         adv,
  input  logic [N-1:0] from,
  output logic [N-1:0] q
);

  vec_t rot_w;
  assign rot_w = rotl1(MAXW'(from), N);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= N'(1);
    else if (adv) q <= rot_w[N-1:0];
  end

  generate
    if (N < MAXW) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^rot_w[MAXW-1:N];
    end
  endgenerate

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter: grants one requester at a time, holds until release or
// hold limit, then rotates the priority token past the previous owner.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  ring_rr_arbiter_if.slave bus
);

  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned HW  = $clog2(MAX_HOLD + 1);

  localparam logic [0:0] IDLE  = ST_IDLE;
  localparam logic [0:0] GRANT = ST_GRANT;

  logic [0:0]     state, state_n;
  logic [N-1:0]   gnt, gnt_n;
  logic           gnt_valid, gnt_valid_n;
  logic [IDW-1:0] gnt_id, gnt_id_n;
  logic           timeout, timeout_n;
  logic [HW-1:0]  hold, hold_n;
  logic [N-1:0]   token;
  logic           adv_c;
  logic           owner_rel_c;
  logic           limit_c;
  vec_t           pick_w;

  assign pick_w      = rr_pick(MAXW'(bus.req), MAXW'(token), N);
  assign owner_rel_c = bus.done[gnt_id] | ~bus.req[gnt_id];
  assign limit_c     = (hold == HW'(MAX_HOLD));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      timeout   <= 1'b0;
      hold      <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      gnt_valid <= gnt_valid_n;
      gnt_id    <= gnt_id_n;
      timeout   <= timeout_n;
      hold      <= hold_n;
    end
  end

  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    gnt_valid_n = gnt_valid;
    gnt_id_n    = gnt_id;
    timeout_n   = 1'b0;
    hold_n      = hold;
    adv_c       = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_n     = GRANT;
          gnt_n       = pick_w[N-1:0];
          gnt_valid_n = 1'b1;
          gnt_id_n    = IDW'(onehot2idx(pick_w));
          hold_n      = HW'(1);
        end
      end
      GRANT: begin
        // Owner release wins over the hold limit, so timeout only flags a forced revoke.
        if (owner_rel_c || limit_c) begin
          state_n     = IDLE;
          gnt_n       = '0;
          gnt_valid_n = 1'b0;
          gnt_id_n    = '0;
          hold_n      = '0;
          adv_c       = 1'b1;
          timeout_n   = limit_c & ~owner_rel_c;
        end else begin
          hold_n = hold + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  token_ring #(.N(N)) u_token (
    .clk   (clk),
    .reset (reset),
    .adv   (adv_c),
    .from  (gnt),
    .q     (token)
  );

  assign bus.gnt       = gnt;
  assign bus.gnt_valid = gnt_valid;
  assign bus.gnt_id    = gnt_id;
  assign bus.timeout   = timeout;
  assign bus.token     = token;

  generate
    if (N < MAXW) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^pick_w[MAXW-1:N];
    end
  endgenerate

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter (N=4, MAX_HOLD=8): vector table plus
// hand sequences for the hold-limit timeout and asynchronous reset.
module tb_ring_rr_arbiter;

  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] id;
    logic [3:0] tok;
    logic       to;
  } vec_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  vec_t vecs[$];

  ring_rr_arbiter_if #(.N(4)) bus ();

  ring_rr_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [3:0] g, input logic v,
                         input logic [1:0] id, input logic [3:0] tk, input logic to);
    chk({tag, ".gnt"},       idx, 32'(bus.gnt),       32'(g));
    chk({tag, ".gnt_valid"}, idx, 32'(bus.gnt_valid), 32'(v));
    chk({tag, ".gnt_id"},    idx, 32'(bus.gnt_id),    32'(id));
    chk({tag, ".token"},     idx, 32'(bus.token),     32'(tk));
    chk({tag, ".timeout"},   idx, 32'(bus.timeout),   32'(to));
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                     input logic v, input logic [1:0] id, input logic [3:0] tk, input logic to);
    vec_t e;
    e.req = r; e.done = d; e.gnt = g; e.valid = v; e.id = id; e.tok = tk; e.to = to;
    vecs.push_back(e);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Full rotation 0,1,2,3,0: each owner releases with done in its second grant cycle.
    add(4'b1111, 4'b0000, 4'b0001, 1, 2'd0, 4'b0001, 0);
    add(4'b1111, 4'b0000, 4'b0001, 1, 2'd0, 4'b0001, 0);
    add(4'b1111, 4'b0001, 4'b0000, 0, 2'd0, 4'b0010, 0);
    add(4'b1111, 4'b0000, 4'b0010, 1, 2'd1, 4'b0010, 0);
    add(4'b1111, 4'b0000, 4'b0010, 1, 2'd1, 4'b0010, 0);
    add(4'b1111, 4'b0010, 4'b0000, 0, 2'd0, 4'b0100, 0);
    add(4'b1111, 4'b0000, 4'b0100, 1, 2'd2, 4'b0100, 0);
    add(4'b1111, 4'b0000, 4'b0100, 1, 2'd2, 4'b0100, 0);
    add(4'b1111, 4'b0100, 4'b0000, 0, 2'd0, 4'b1000, 0);
    add(4'b1111, 4'b0000, 4'b1000, 1, 2'd3, 4'b1000, 0);
    add(4'b1111, 4'b0000, 4'b1000, 1, 2'd3, 4'b1000, 0);
    add(4'b1111, 4'b1000, 4'b0000, 0, 2'd0, 4'b0001, 0);
    add(4'b1111, 4'b0000, 4'b0001, 1, 2'd0, 4'b0001, 0);
    add(4'b1111, 4'b0000, 4'b0001, 1, 2'd0, 4'b0001, 0);
    add(4'b1111, 4'b0001, 4'b0000, 0, 2'd0, 4'b0010, 0);
    // Done pulses in IDLE are ignored.
    add(4'b0000, 4'b1111, 4'b0000, 0, 2'd0, 4'b0010, 0);
    // Grant id 1, then drop req[1] with a stray done[3] on the same edge.
    add(4'b0010, 4'b0000, 4'b0010, 1, 2'd1, 4'b0010, 0);
    add(4'b0000, 4'b1000, 4'b0000, 0, 2'd0, 4'b0100, 0);
    add(4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 4'b0100, 0);
    // Stray done for a non-owner mid-grant has no effect; owner done on hold==8 gives no timeout.
    add(4'b0100, 4'b0000, 4'b0100, 1, 2'd2, 4'b0100, 0);
    add(4'b0100, 4'b1011, 4'b0100, 1, 2'd2, 4'b0100, 0);
    for (int i = 0; i < 6; i++) add(4'b0100, 4'b0000, 4'b0100, 1, 2'd2, 4'b0100, 0);
    add(4'b0100, 4'b0100, 4'b0000, 0, 2'd0, 4'b1000, 0);
    add(4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 4'b1000, 0);

    reset    = 1'b1;
    bus.req  = '0;
    bus.done = '0;
    #12;
    chk_all("reset", 0, 4'b0000, 0, 2'd0, 4'b0001, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("idle", i, 4'b0000, 0, 2'd0, 4'b0001, 0);
    end

    foreach (vecs[i]) begin
      bus.req  = vecs[i].req;
      bus.done = vecs[i].done;
      tick();
      chk_all("vec", i, vecs[i].gnt, vecs[i].valid, vecs[i].id, vecs[i].tok, vecs[i].to);
    end

    // Hold limit: token 1000, req 0100 never released -> 8 grant cycles then timeout.
    bus.req  = 4'b0100;
    bus.done = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all("hold", i, 4'b0100, 1, 2'd2, 4'b1000, 0);
    end
    tick();
    chk_all("tmo", 0, 4'b0000, 0, 2'd0, 4'b1000, 1);
    tick();
    chk_all("regrant", 0, 4'b0100, 1, 2'd2, 4'b1000, 0);

    // Move to a grant of id 1 and reach hold count 5.
    bus.req = 4'b0000;
    tick();
    chk_all("drop", 0, 4'b0000, 0, 2'd0, 4'b1000, 0);
    bus.req = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("g1", i, 4'b0010, 1, 2'd1, 4'b1000, 0);
    end

    // Asynchronous reset mid-grant, away from the clock edge.
    #2;
    reset = 1'b1;
    #1;
    chk_all("areset", 0, 4'b0000, 0, 2'd0, 4'b0001, 0);
    bus.req = 4'b0011;
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk_all("post_reset", 0, 4'b0001, 1, 2'd0, 4'b0001, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
